// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM read-port arbiter.
//   id_width() : requester-id width, $clog2(n) with a floor of 1
//   RSP_DEPTH  : response buffer depth (the credit limit)
// The {id, data} response entry is a packed struct typedef'd inside the top
// module, sized from id_width() and DATA_WIDTH.
package ram_arb_pkg;

    localparam int unsigned RSP_DEPTH = 2;

    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/ram_read_arbiter_if.sv
// Request/response channels between NUM_REQ requesters and the arbiter.
//   req_valid/req_ready/req_addr : per-requester read request channel
//   rsp_valid/rsp_ready          : per-requester response handshake
//   rsp_data                     : shared response data, qualified by rsp_valid
// Modports: master = requester side, slave = arbiter side.
interface ram_read_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [NUM_REQ-1:0]                 rsp_ready;
    logic [DATA_WIDTH-1:0]              rsp_data;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ram_read_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting index at or after
// last_grant+1 (wrapping); last_grant moves only when advance is high.
//   clk, rst   : clock, synchronous active-high reset
//   req        : request bits
//   enable     : grant permitted this cycle
//   advance    : grant was taken (handshake)
//   grant      : one-hot grant (zero when disabled or no request)
//   grant_idx  : index of the granted requester
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IW      = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    logic [IW-1:0] last_grant;

    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (enable) begin
            for (int unsigned k = NUM_REQ; k >= 1; k--) begin
                automatic int unsigned idx = (32'(last_grant) + k) % NUM_REQ;
                if (req[IW'(idx)]) begin
                    grant     = NUM_REQ'(1) << idx;
                    grant_idx = IW'(idx);
                end
            end
        end
    end

    // Reset to the last index so requester 0 has priority first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IW'(NUM_REQ - 1);
        end else if (advance) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/ram_read_arbiter.sv
// Shares one 1-cycle-latency RAM read port among NUM_REQ requesters.
// Round-robin grant, one read per cycle, responses returned in issue order
// through a 2-entry buffer so the RAM never stalls.
//   clk, rst       : clock, synchronous active-high reset
//   bus (slave)    : request/response channels of all requesters
//   ram_read_addr  : RAM read address (holds last value when idle)
//   ram_read_data  : RAM read data, valid the cycle after the address
//   grant_count    : per-requester saturating handshake counters
// Optional feature: define LIBSTF_RAM_ARB_STATS_EN to build the counters;
// otherwise grant_count is tied to zero.
module ram_read_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    ram_read_arbiter_if.slave            bus,
    output logic [ADDR_WIDTH-1:0]        ram_read_addr,
    input  logic [DATA_WIDTH-1:0]        ram_read_data,
    output logic [NUM_REQ-1:0][31:0]     grant_count
);

    localparam int unsigned IW    = id_width(NUM_REQ);
    localparam int unsigned OCC_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned CW    = OCC_W + 1;

    typedef struct packed {
        logic [IW-1:0]         id;
        logic [DATA_WIDTH-1:0] data;
    } rsp_entry_t;

    logic [OCC_W-1:0]      occ;
    logic                  inflight_valid;
    logic [IW-1:0]         inflight_id;
    rsp_entry_t            buf_q [RSP_DEPTH];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [ADDR_WIDTH-1:0] addr_q;
    rsp_entry_t            head;
    logic                  rsp_any;
    logic                  push;
    logic                  pop;
    logic                  credit_ok;
    logic                  issue;
    logic [NUM_REQ-1:0]    grant;
    logic [IW-1:0]         grant_idx;

    assign head    = buf_q[rd_ptr];
    assign rsp_any = (occ != '0) && !rst;
    assign pop     = rsp_any && bus.rsp_ready[head.id];
    assign push    = inflight_valid;

    // Issue only if the read cannot overflow the buffer: occ + inflight - pop < depth.
    assign credit_ok = (CW'(occ) + CW'(inflight_valid)) < (CW'(RSP_DEPTH) + CW'(pop));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .enable    (credit_ok && !rst),
        .advance   (issue),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign issue         = |grant;
    assign bus.req_ready = grant;
    assign ram_read_addr = issue ? bus.req_addr[grant_idx] : addr_q;

    // Head of the buffer drives the response of its owner only.
    always_comb begin
        bus.rsp_valid = '0;
        if (rsp_any) begin
            bus.rsp_valid[head.id] = 1'b1;
        end
    end
    assign bus.rsp_data = head.data;

    // Control state: in-flight tracker, pointers, occupancy, idle address.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ            <= '0;
            inflight_valid <= 1'b0;
            inflight_id    <= '0;
            rd_ptr         <= 1'b0;
            wr_ptr         <= 1'b0;
            addr_q         <= '0;
        end else begin
            inflight_valid <= issue;
            if (issue) begin
                inflight_id <= grant_idx;
                addr_q      <= bus.req_addr[grant_idx];
            end
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Buffer storage; contents are don't-care while occ says empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_q[wr_ptr] <= '{id: inflight_id, data: ram_read_data};
        end
    end

`ifdef LIBSTF_RAM_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        always_ff @(posedge clk) begin
            if (rst) begin
                grant_count[gi] <= '0;
            end else if (grant[gi] && (grant_count[gi] != '1)) begin
                grant_count[gi] <= grant_count[gi] + 32'd1;
            end
        end
    end
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Randomized scoreboard bench for ram_read_arbiter with a behavioural RAM.
module tb_ram_read_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          t;
    } exp_t;

    logic clk;
    logic rst;
    logic [AW-1:0]        ram_read_addr;
    logic [DW-1:0]        ram_read_data;
    logic [N-1:0][31:0]   grant_count;

    ram_read_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_read_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .ram_read_addr (ram_read_addr),
        .ram_read_data (ram_read_data),
        .grant_count   (grant_count)
    );

    logic [31:0] mem [1024];
    always @(posedge clk) ram_read_data <= mem[ram_read_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    int          last_g = N - 1;
    logic [AW-1:0] m_addr = '0;
    int          cnt[N];
    logic [N-1:0] hs = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: outstanding reads = scoreboard entries; response due two cycles after issue.
    always @(negedge clk) begin : model
        logic [N-1:0] erv;
        logic [N-1:0] erq;
        int j;
        if (rst) begin
            check("rst_req_ready", bus.req_ready, '0);
            check("rst_rsp_valid", bus.rsp_valid, '0);
            q.delete();
            last_g = N - 1;
            m_addr = '0;
            for (int i = 0; i < N; i++) cnt[i] = 0;
            hs = '0;
        end else begin
            erv = '0;
            if (q.size() > 0 && cyc >= q[0].t + 2) erv[q[0].id] = 1'b1;
            check("rsp_valid", bus.rsp_valid, erv);
            if (erv != '0) begin
                check("rsp_data", bus.rsp_data, q[0].data);
                if (bus.rsp_ready[q[0].id]) void'(q.pop_front());
            end
            erq = '0;
            if (q.size() < 2) begin
                for (int k = 1; k <= N; k++) begin
                    j = (last_g + k) % N;
                    if (bus.req_valid[j]) begin
                        erq[j] = 1'b1;
                        break;
                    end
                end
            end
            check("req_ready", bus.req_ready, erq);
            if (erq != '0) begin
                m_addr = bus.req_addr[j];
                q.push_back('{id: j, data: mem[bus.req_addr[j]], t: cyc});
                last_g = j;
                cnt[j]++;
            end
            check("ram_read_addr", ram_read_addr, m_addr);
            hs = erq;
        end
    end

    logic [N-1:0] en_mask = '0;
    int           p_valid = 0;
    int           addr_mode = 0;
    int unsigned  seq_addr[N];

    task automatic update_reqs();
        for (int i = 0; i < N; i++) begin
            if (hs[i]) bus.req_valid[i] = 1'b0;
            if (!bus.req_valid[i] && en_mask[i] && ($urandom_range(99) < p_valid)) begin
                if (addr_mode == 1) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_addr[i]  = AW'(i * 16);
                end else if (addr_mode == 2) begin
                    if (seq_addr[i] < 8) begin
                        bus.req_valid[i] = 1'b1;
                        bus.req_addr[i]  = AW'(seq_addr[i]);
                        seq_addr[i]++;
                    end
                end else begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_addr[i]  = AW'($urandom);
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] rr);
        @(posedge clk);
        #1;
        update_reqs();
        bus.rsp_ready = rr;
    endtask

    task automatic check_stats(input string name);
        for (int i = 0; i < N; i++) begin
`ifdef LIBSTF_RAM_ARB_STATS_EN
            check(name, grant_count[i], 64'(cnt[i]));
`else
            check(name, grant_count[i], '0);
`endif
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.rsp_ready = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[5] = 32'hA5A5_0001;
        for (int i = 0; i < N; i++) seq_addr[i] = 0;
        repeat (3) step('1);
        rst = 1'b0;
        check_stats("stats_reset");

        // Single request: requester 2 reads address 5.
        repeat (6) step('1);
        bus.req_valid[2] = 1'b1;
        bus.req_addr[2]  = AW'(5);
        repeat (6) step('1);

        // Round-robin with all requesters continuously valid.
        en_mask = '1; p_valid = 100; addr_mode = 1;
        repeat (12) step('1);
        en_mask = '0;
        repeat (6) step('1);

        // Backpressure on requester 1 streaming addresses 0..7.
        en_mask = 4'b0010; addr_mode = 2;
        for (int c = 0; c < 24; c++) step((c >= 3 && c < 11) ? 4'b1101 : 4'b1111);
        en_mask = '0;
        repeat (4) step('1);

        // Head blocking: requester 0 stalled while requester 3 waits behind it.
        bus.req_valid[0] = 1'b1; bus.req_addr[0] = AW'($urandom);
        bus.req_valid[3] = 1'b1; bus.req_addr[3] = AW'($urandom);
        repeat (4) step(4'b1110);
        repeat (6) step('1);

        // Random traffic.
        en_mask = '1; addr_mode = 0;
        for (int c = 0; c < 1500; c++) begin
            p_valid = (c < 750) ? 60 : 95;
            step(N'($urandom) | N'($urandom));
        end
        en_mask = '0;
        repeat (10) step('1);
        check_stats("stats_random");

        // Reset mid-stream with reads buffered and in flight.
        en_mask = '1; p_valid = 100;
        repeat (5) step('1);
        repeat (3) step('0);
        rst = 1'b1;
        step('1);
        rst = 1'b0;
        repeat (20) step('1);

        // Stats: 100 grants to requester 3 after a reset.
        en_mask = '0;
        repeat (6) step('1);
        rst = 1'b1;
        step('1);
        rst = 1'b0;
        en_mask = 4'b1000; p_valid = 100;
        for (int g = 0; g < 1000 && cnt[3] < 100; g++) begin
            step('1);
            @(negedge clk);
            #1;
            if (cnt[3] >= 100) en_mask = '0;
        end
        en_mask = '0;
        repeat (8) step('1);
`ifdef LIBSTF_RAM_ARB_STATS_EN
        check("stats_req3", grant_count[3], 64'd100);
`else
        check("stats_req3", grant_count[3], '0);
`endif
        for (int i = 0; i < 3; i++) check("stats_other", grant_count[i], '0);

        repeat (10) step('1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_read_arbiter.md
# ram_read_arbiter

Shares the single read port of a `RAM` instance (fixed 1-cycle read latency, plain `RAM` with `READ_DURING_WRITE`/`READ_AFTER_WRITE` as configured) between `NUM_REQ` requesters. Each requester has a valid/ready request channel and a response channel. Grants are round-robin, and the block sustains one read per cycle. A small response buffer absorbs backpressure so the RAM never has to stall. The write port of the RAM is not touched by this block.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 32: RAM word width.
- `ADDR_WIDTH`, 10: RAM address width.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  request valid per requester.
- `req_ready`  out  `NUM_REQ`  request accepted (one-hot or zero).
- `req_addr`  in  `NUM_REQ` x `ADDR_WIDTH`  read address per requester.
- `rsp_valid`  out  `NUM_REQ`  response valid, one-hot or zero.
- `rsp_ready`  in  `NUM_REQ`  response ready per requester.
- `rsp_data`  out  `DATA_WIDTH`  response data, shared bus, qualified by `rsp_valid`.
- `ram_read_addr`  out  `ADDR_WIDTH`  to `RAM.read_addr`.
- `ram_read_data`  in  `DATA_WIDTH`  from `RAM.read_data`.
- `grant_count`  out  `NUM_REQ` x 32  per-requester accepted-request counters (see Configuration).

## Operation
- **Credit rule.** Issue is allowed when `occ + inflight - pop < 2`.
  - `occ` is the response buffer occupancy, 0..2.
  - `inflight` is 1 if a read was issued in the previous cycle.
  - `pop` is 1 if the buffer head handshakes this cycle.
- **Grant.** When issue is allowed and any `req_valid` is high, exactly one requester is granted.
  - The grant goes to the first valid requester at or after `last_grant+1`, wrapping modulo `NUM_REQ`.
  - `req_ready[g]=1` for the granted requester only.
  - `ram_read_addr = req_addr[g]`, combinational.
  - `last_grant` updates only on a handshake.
- **Request ready.** `req_ready` depends on `req_valid` and on the credit state. It never depends on `req_addr`.
- **Idle RAM address.** When nothing is granted, `ram_read_addr` holds its last value, so the RAM output is not toggled.
- **In-flight tracking.** The in-flight register stores {valid, requester id}.
  - On the next edge, `ram_read_data` and the id are pushed into the 2-entry response FIFO.
- **Response output.** From the buffer head: `rsp_valid[id]=1`, `rsp_data=head data`.
  - A pop happens on `rsp_valid[id] && rsp_ready[id]`.
  - `rsp_ready` of other requesters is ignored.
- **Ordering.** Responses are returned in global issue order. A stalled head blocks all other requesters' responses; this is intended.
- **Simultaneous push and pop.** Occupancy is unchanged. No overflow is possible by the credit rule.
- **Write collisions.** Same-cycle RAM write/read collisions are resolved by the `RAM` configuration, not by this block.

## Timing
- **Latency.** A request handshake at edge t gives `rsp_valid` high from edge t+2 (cycle t+2).
- **Throughput.** With all `rsp_ready` high, the block issues 1 read/cycle sustained.
- **Backpressure.** After `rsp_ready` drops, at most 2 further responses are buffered. `req_ready` goes low within 1 cycle and stays low until a pop.
- **Reset values:**
  - `req_ready=0` while `rst` is high.
  - `rsp_valid=0`, `occ=0`, `inflight=0`.
  - `last_grant=NUM_REQ-1`, so requester 0 has priority first.
  - `ram_read_addr=0`.
  - `grant_count=0`.
- **Reset mid-operation.** In-flight and buffered reads are dropped. RAM data arriving in the cycle after reset deasserts is discarded.
- **Stability.** `rsp_valid`/`rsp_data` are held stable while not accepted. Requesters must hold `req_valid`/`req_addr` until `req_ready`.

## Configuration
- **`LIBSTF_RAM_ARB_STATS_EN` defined:**
  - `grant_count[i]` increments on every request handshake of requester i.
  - Counters saturate at 2^32-1 and are cleared by `rst`.
- **Undefined:** `grant_count` is tied to 0 and no counter logic is synthesized. The port list is identical in both builds.

## Structure
- **Package `ram_arb_pkg`:**
  - `localparam`-style function `id_width(NUM_REQ)=$clog2(NUM_REQ)` with a minimum of 1.
  - Typedef for the FIFO entry struct {id, data} as a parameterized helper.
  - Constant `RSP_DEPTH=2`.
- **Sub-module `rr_arbiter`:**
  - Inputs `NUM_REQ` request bits, enable, and `advance` (handshake).
  - Outputs a one-hot grant and the grant index.
  - Owns the `last_grant` register.
- **Top level:** credit logic, in-flight register, 2-entry buffer, stats counters.

## Test plan
- **Single request.** Preload `RAM[5]=0xA5A5_0001`; requester 2 requests addr 5 at cycle 10 → `req_ready[2]` at cycle 10, `rsp_valid=4'b0100` with `rsp_data=0xA5A5_0001` at cycle 12.
- **Round-robin fairness.** All 4 valid continuously with addresses `i*16`, `rsp_ready=1` → grants 0,1,2,3,0,… one per cycle; 8 responses in order over 8 cycles.
- **Backpressure.** Requester 1 streams addresses 0..7 and `rsp_ready[1]` is low for cycles 5–12 → exactly 2 responses buffered, `req_ready[1]` low until the first pop, no data lost or reordered.
- **Head blocking.** Requester 0 then requester 3 issue back-to-back; `rsp_ready[0]=0` for 4 cycles → requester 3's response is not presented until requester 0's pops.
- **Reset mid-stream.** Assert `rst` for 1 cycle with 1 read in flight and 2 buffered → all `rsp_valid=0` the next cycle, no stale response afterwards, and the first grant after reset goes to requester 0.
- **Stats.** With the macro defined, 100 grants to requester 3 → `grant_count[3]=100`, others 0. Without the macro → all 0.
